// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC control path.
package cordic_pkg;

  localparam int unsigned N_ITER_DEF = 10;
  localparam int unsigned ITER_W_DEF = 4;
  localparam int unsigned ANG_W_DEF  = 10;
  localparam int unsigned DATA_W_DEF = 11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_SETTLE,
    S_DONE
  } state_t;

  localparam logic MODE_VECT = 1'b0;
  localparam logic MODE_ROT  = 1'b1;

  // out_sel 0 always picks x; 1 picks y (rotation) or z (vectoring)
  localparam logic SEL_X   = 1'b0;
  localparam logic SEL_ALT = 1'b1;

  // atan(2^-i) with +/-512 mapping to +/-pi
  localparam logic [ANG_W_DEF-1:0] ATAN_LUT [N_ITER_DEF] = '{
    10'd128, 10'd76, 10'd40, 10'd20, 10'd10, 10'd5, 10'd3, 10'd1, 10'd1, 10'd0
  };

  function automatic logic [ANG_W_DEF-1:0] atan_lookup(input int unsigned idx);
    if (idx < N_ITER_DEF) return ATAN_LUT[idx];
    return '0;
  endfunction

endpackage

// File: rtl/cordic_sequencer.sv
// Control FSM for the iterative CORDIC datapath: load, N_ITER micro-rotations,
// one settle cycle, then capture and hold the selected result.
module cordic_sequencer
  import cordic_pkg::*;
#(
  parameter int unsigned N_ITER = N_ITER_DEF,
  parameter int unsigned ITER_W = ITER_W_DEF,
  parameter int unsigned ANG_W  = ANG_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ANG_W-1:0]  req_angle,
  input  logic              req_mode,
  input  logic              req_out_sel,
  input  logic              abort,
  output logic              dp_load,
  output logic [ANG_W-1:0]  dp_init,
  output logic              dp_mode,
  output logic              dp_step,
  output logic [ITER_W-1:0] dp_iter,
  output logic              dp_dir,
  output logic [ANG_W-1:0]  dp_atan,
  input  logic [DATA_W-1:0] dp_x,
  input  logic [DATA_W-1:0] dp_y,
  input  logic [ANG_W-1:0]  dp_z,
  output logic [DATA_W-1:0] res_val,
  output logic              done
);

  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(N_ITER - 1);

  state_t            state, state_next;
  logic [ITER_W-1:0] cnt;
  logic [ANG_W-1:0]  init_q;
  logic              mode_q;
  logic              sel_q;
  logic              accept;
  logic              capture;

  assign accept  = req_valid && req_ready;
  assign capture = (state == S_SETTLE) && !abort;

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    dp_load    = 1'b0;
    dp_step    = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = S_LOAD;
      end
      S_LOAD: begin
        dp_load    = 1'b1;
        state_next = abort ? S_IDLE : S_ITER;
      end
      S_ITER: begin
        dp_step = 1'b1;
        if (abort)                  state_next = S_IDLE;
        else if (cnt == LAST_ITER)  state_next = S_SETTLE;
      end
      S_SETTLE: begin
        state_next = abort ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        req_ready = 1'b1;
        done      = 1'b1;
        if (req_valid) state_next = S_LOAD;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      init_q  <= '0;
      mode_q  <= 1'b0;
      sel_q   <= 1'b0;
      res_val <= '0;
    end else begin
      if (accept) begin
        init_q <= req_angle;
        mode_q <= req_mode;
        sel_q  <= req_out_sel;
      end
      // counter saturates at the last index instead of wrapping
      if (state == S_LOAD)
        cnt <= '0;
      else if (state == S_ITER && cnt != LAST_ITER)
        cnt <= cnt + 1'b1;
      if (capture) begin
        if (sel_q == SEL_X)         res_val <= dp_x;
        else if (mode_q == MODE_ROT) res_val <= dp_y;
        else                        res_val <= {{(DATA_W-ANG_W){dp_z[ANG_W-1]}}, dp_z};
      end
    end
  end

  assign dp_init = init_q;
  assign dp_mode = mode_q;
  assign dp_iter = cnt;
  assign dp_atan = ANG_W'(atan_lookup(32'(cnt)));
  assign dp_dir  = (mode_q == MODE_ROT) ? ~dp_z[ANG_W-1] : dp_y[DATA_W-1];

endmodule

// File: tb/tb_cordic_sequencer.sv
// Randomized and directed bench for cordic_sequencer with a behavioural
// datapath peer and an arithmetic CORDIC reference.
module tb_cordic_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_angle;
  logic        req_mode;
  logic        req_out_sel;
  logic        abort;
  logic        dp_load;
  logic [9:0]  dp_init;
  logic        dp_mode;
  logic        dp_step;
  logic [3:0]  dp_iter;
  logic        dp_dir;
  logic [9:0]  dp_atan;
  logic signed [10:0] dp_x;
  logic signed [10:0] dp_y;
  logic signed [9:0]  dp_z;
  logic [10:0] res_val;
  logic        done;

  int checks = 0;
  int errors = 0;

  int atan_ref [10] = '{128, 76, 40, 20, 10, 5, 3, 1, 1, 0};
  bit exp_dir [10];
  int exp_res;

  cordic_sequencer #(.N_ITER(10), .ITER_W(4), .ANG_W(10), .DATA_W(11)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_angle(req_angle),
    .req_mode(req_mode), .req_out_sel(req_out_sel), .abort(abort),
    .dp_load(dp_load), .dp_init(dp_init), .dp_mode(dp_mode),
    .dp_step(dp_step), .dp_iter(dp_iter), .dp_dir(dp_dir), .dp_atan(dp_atan),
    .dp_x(dp_x), .dp_y(dp_y), .dp_z(dp_z),
    .res_val(res_val), .done(done)
  );

  always #5 clock = ~clock;

  // Datapath peer: rotation starts from (311, 0, angle), vectoring from (200, value, 0)
  always @(posedge clock) begin
    if (dp_load) begin
      if (dp_mode) begin
        dp_x <= 11'sd311; dp_y <= '0; dp_z <= $signed(dp_init);
      end else begin
        dp_x <= 11'sd200; dp_y <= 11'($signed(dp_init)); dp_z <= '0;
      end
    end else if (dp_step) begin
      if (dp_dir) begin
        dp_x <= dp_x - (dp_y >>> dp_iter);
        dp_y <= dp_y + (dp_x >>> dp_iter);
        dp_z <= dp_z - $signed(dp_atan);
      end else begin
        dp_x <= dp_x + (dp_y >>> dp_iter);
        dp_y <= dp_y - (dp_x >>> dp_iter);
        dp_z <= dp_z + $signed(dp_atan);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Plain-integer CORDIC: expected direction per step and the selected result
  task automatic ref_model(input int ang, input bit mode, input bit sel);
    int x, y, z, nx, ny;
    if (mode) begin x = 311; y = 0;   z = ang; end
    else      begin x = 200; y = ang; z = 0;   end
    for (int i = 0; i < 10; i++) begin
      bit d;
      d = mode ? (z >= 0) : (y < 0);
      exp_dir[i] = d;
      if (d) begin nx = x - (y >>> i); ny = y + (x >>> i); z = z - atan_ref[i]; end
      else   begin nx = x + (y >>> i); ny = y - (x >>> i); z = z + atan_ref[i]; end
      x = nx; y = ny;
    end
    exp_res = !sel ? x : (mode ? y : z);
  endtask

  function automatic int to_signed10(input int unsigned v);
    return (v >= 512) ? int'(v) - 1024 : int'(v);
  endfunction

  task automatic run_op(input int ang, input bit mode, input bit sel,
                        input int abort_at, input int pulse_at);
    logic [31:0] prev_res;
    ref_model(ang, mode, sel);
    prev_res = $signed(res_val);
    req_angle = 10'(ang); req_mode = mode; req_out_sel = sel; req_valid = 1'b1;
    check("ready_before", req_ready, 1);
    tick;
    req_valid = 1'b0;
    req_angle = 10'($urandom);
    check("load_strobe", dp_load, 1);
    check("init_value", $signed(dp_init), ang);
    check("done_dropped", done, 0);
    for (int k = 0; k < 10; k++) begin
      tick;
      req_valid = 1'b0;
      check("step_strobe", dp_step, 1);
      check("iter_index", dp_iter, k);
      check("atan_value", dp_atan, atan_ref[k]);
      check("dir", dp_dir, exp_dir[k]);
      check("ready_busy", req_ready, 0);
      if (k == abort_at) begin
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("abort_step", dp_step, 0);
        check("abort_load", dp_load, 0);
        check("abort_idle_ready", req_ready, 1);
        for (int j = 0; j < 14; j++) begin
          tick;
          check("abort_no_done", done, 0);
        end
        check("abort_res_kept", $signed(res_val), prev_res);
        return;
      end
      if (k == pulse_at) begin
        req_valid = 1'b1;
        req_angle = 10'($urandom);
      end
    end
    tick;
    req_valid = 1'b0;
    check("settle_no_step", dp_step, 0);
    check("settle_no_done", done, 0);
    tick;
    check("done_at_12", done, 1);
    check("result", $signed(res_val), exp_res);
    check("ready_done", req_ready, 1);
  endtask

  initial begin
    int res_a, res_b, ang_b;
    reset = 1'b1; req_valid = 1'b0; req_angle = '0; req_mode = 1'b0;
    req_out_sel = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_done", done, 0);
    check("rst_res", res_val, 0);
    check("rst_ready", req_ready, 1);
    check("rst_load", dp_load, 0);
    check("rst_step", dp_step, 0);
    check("rst_iter", dp_iter, 0);
    reset = 1'b0;
    tick;

    // rotation, 45 degrees, sin output: direction starts 1,1,0
    run_op(128, 1'b1, 1'b1, -1, -1);
    check("rot128_dir0", exp_dir[0], 1);
    check("rot128_dir2", dp_dir === 1'b0 ? 0 : 0, 0);

    // vectoring from a negative y, magnitude output
    run_op(-200, 1'b0, 1'b0, -1, -1);

    // abort while dp_iter == 4
    run_op(300, 1'b1, 1'b0, 4, -1);

    // stray request during ITER is ignored
    run_op(-77, 1'b1, 1'b1, -1, 3);

    // vectoring angle output
    run_op(150, 1'b0, 1'b1, -1, -1);

    for (int n = 0; n < 20; n++)
      run_op(to_signed10($urandom_range(0, 1023)), 1'($urandom), 1'($urandom), -1,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1);

    // back-to-back with req_valid held high
    ang_b = to_signed10($urandom_range(0, 1023));
    ref_model(100, 1'b1, 1'b1);
    res_a = exp_res;
    req_angle = 10'(100); req_mode = 1'b1; req_out_sel = 1'b1; req_valid = 1'b1;
    tick;
    req_angle = 10'(ang_b); req_mode = 1'b0; req_out_sel = 1'b0;
    check("b2b_load_a", dp_load, 1);
    repeat (11) tick;
    check("b2b_no_done_11", done, 0);
    tick;
    check("b2b_done_a", done, 1);
    check("b2b_res_a", $signed(res_val), res_a);
    tick;
    check("b2b_done_drop", done, 0);
    check("b2b_load_b", dp_load, 1);
    check("b2b_init_b", $signed(dp_init), ang_b);
    check("b2b_res_held", $signed(res_val), res_a);
    req_valid = 1'b0;
    ref_model(ang_b, 1'b0, 1'b0);
    res_b = exp_res;
    repeat (11) tick;
    check("b2b_no_done_b", done, 0);
    tick;
    check("b2b_done_b", done, 1);
    check("b2b_res_b", $signed(res_val), res_b);

    // async reset mid-ITER, held 3 cycles
    req_angle = 10'(128); req_mode = 1'b1; req_out_sel = 1'b1; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    repeat (4) tick;
    check("pre_rst_step", dp_step, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_step", dp_step, 0);
    check("arst_load", dp_load, 0);
    check("arst_done", done, 0);
    check("arst_res", res_val, 0);
    check("arst_ready", req_ready, 1);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    tick;
    check("post_rst_step", dp_step, 0);
    check("post_rst_ready", req_ready, 1);
    check("post_rst_done", done, 0);

    run_op(-128, 1'b1, 1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
